decode_stage: RTL

//  Parametrised RISC-V-lite ID stage: integer register file, operand read, immediate generation
//  and one ID/EX pipeline register with valid/ready handshake, flush and stall-hold.

---
 rtl/decode_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: RISC-V-lite instruction decode stage.
//   Integer register file (x0 hardwired to zero), operand read, immediate generation and
//   a single ID/EX pipeline register with a valid/ready handshake, flush and stall-hold.
//   While the ID/EX register is held, write-back to a held source register updates the
//   held operand so the instruction never leaves with a stale value.
// Parameters:
//   NBITS  datapath width (>= 32); immediates sign-extend to NBITS
//   NREGS  architectural registers, 32 (RV32I) or 16 (RV32E)
// Optional feature (macro DECODE_WB_BYPASS_EN):
//   defined     - an operand read in the accept cycle returns wb_data on a matching write-back
//   not defined - accept-cycle read returns the pre-write register file contents
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid/in_ready, ir_in, npc_in              fetch side
//   wb_we, wb_addr, wb_data                        write-back port into the register file
//   out_valid/out_ready, rd1, rd2, imm_out, npc_out, rs1_o, rs2_o, rd_o, ir_o, illegal
module decode_stage #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      ir_in,
    input  logic [NBITS-1:0] npc_in,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [NBITS-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] rd1,
    output logic [NBITS-1:0] rd2,
    output logic [NBITS-1:0] imm_out,
    output logic [NBITS-1:0] npc_out,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [31:0]      ir_o,
    output logic             illegal
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [NBITS-1:0] rf [NREGS];

    logic             out_valid_q, illegal_q;
    logic [NBITS-1:0] rd1_q, rd2_q, imm_q, npc_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [31:0]      ir_q;

    logic [4:0]       rs1_f, rs2_f, rd_f;
    logic             rs1_oob, rs2_oob, rd_oob, wb_oob;
    logic [NBITS-1:0] rs1_val, rs2_val, imm_d;
    logic             illegal_d, accept, hold;
    logic             refresh1, refresh2;

    assign rs1_f   = ir_in[19:15];
    assign rs2_f   = ir_in[24:20];
    assign rd_f    = ir_in[11:7];
    assign rs1_oob = {1'b0, rs1_f} >= NREGS_W;
    assign rs2_oob = {1'b0, rs2_f} >= NREGS_W;
    assign rd_oob  = {1'b0, rd_f} >= NREGS_W;
    assign wb_oob  = {1'b0, wb_addr} >= NREGS_W;

    assign in_ready = rst & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign hold     = out_valid_q & ~out_ready;

    // Held-operand refresh: only registers that actually exist can be written back.
    assign refresh1 = wb_we && !wb_oob && wb_addr == rs1_q && rs1_q != 5'd0;
    assign refresh2 = wb_we && !wb_oob && wb_addr == rs2_q && rs2_q != 5'd0;

    // Operand read; out-of-range indices and x0 read zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_f != 5'd0 && !rs1_oob) rs1_val = rf[rs1_f[AW-1:0]];
        if (rs2_f != 5'd0 && !rs2_oob) rs2_val = rf[rs2_f[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we && wb_addr == rs1_f && rs1_f != 5'd0 && !rs1_oob) rs1_val = wb_data;
        if (wb_we && wb_addr == rs2_f && rs2_f != 5'd0 && !rs2_oob) rs2_val = wb_data;
`endif
    end

    // Immediate generation and legality check.
    always_comb begin
        logic [31:0] imm32;
        logic        use_rs1, use_rs2, use_rd, op_bad;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        op_bad  = 1'b0;
        case (ir_in[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                imm32   = {{20{ir_in[31]}}, ir_in[31:20]};
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            7'b0100011: begin
                imm32   = {{20{ir_in[31]}}, ir_in[31:25], ir_in[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1100011: begin
                imm32   = {{19{ir_in[31]}}, ir_in[31], ir_in[7], ir_in[30:25], ir_in[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                imm32  = {ir_in[31:12], 12'b0};
                use_rd = 1'b1;
            end
            7'b1101111: begin
                imm32  = {{11{ir_in[31]}}, ir_in[31], ir_in[19:12], ir_in[20], ir_in[30:21], 1'b0};
                use_rd = 1'b1;
            end
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            default: op_bad = 1'b1;
        endcase
        imm_d     = NBITS'($signed(imm32));
        illegal_d = op_bad | (use_rs1 & rs1_oob) | (use_rs2 & rs2_oob) | (use_rd & rd_oob);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf          <= '{default: '0};
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            npc_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ir_q        <= '0;
        end else begin
            if (wb_we && wb_addr != 5'd0 && !wb_oob) rf[wb_addr[AW-1:0]] <= wb_data;

            if (flush) begin
                // Flush kills the held instruction and drops any simultaneous accept.
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                illegal_q   <= illegal_d;
                rd1_q       <= rs1_val;
                rd2_q       <= rs2_val;
                imm_q       <= imm_d;
                npc_q       <= npc_in;
                rs1_q       <= rs1_f;
                rs2_q       <= rs2_f;
                rd_q        <= rd_f;
                ir_q        <= ir_in;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end else if (hold) begin
                if (refresh1) rd1_q <= wb_data;
                if (refresh2) rd2_q <= wb_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign rd1       = rd1_q;
    assign rd2       = rd2_q;
    assign imm_out   = imm_q;
    assign npc_out   = npc_q;
    assign rs1_o     = rs1_q;
    assign rs2_o     = rs2_q;
    assign rd_o      = rd_q;
    assign ir_o      = ir_q;

endmodule
